// File: rtl/tseq_ctrl_if.sv
// Request/result handshake between a conversion requester and tseq_ctrl.
// The master raises start/ch_sel and ready; the sequencer reports busy, valid and result.
interface tseq_ctrl_if #(
    parameter int CH_W  = 2,
    parameter int RES_W = 7
);
    logic             start;
    logic [CH_W-1:0]  ch_sel;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [RES_W-1:0] result;

    modport master (output start, ch_sel, ready, input  busy, valid, result);
    modport slave  (input  start, ch_sel, ready, output busy, valid, result);
endinterface

// File: rtl/tseq_ctrl.sv
// Diode temperature-sensor sequencer: precharge, then 2^OSR_W diode/bigdiode/charge iterations counting comparator ones.
// Latency: 1 + PRE_CYC + 2^OSR_W*(2+2*PH_CYC) + CHG_CYC*ones cycles from start sample to valid.
// Backpressure: result held in DONE until ready; start ignored while busy. Macro TSEQ_CHOP_EN enables comparator chopping.
module tseq_ctrl #(
    parameter  int N_CH    = 4,
    parameter  int OSR_W   = 6,
    parameter  int PRE_CYC = 26,
    parameter  int PH_CYC  = 8,
    parameter  int CHG_CYC = 5,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int RES_W   = OSR_W + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    tseq_ctrl_if.slave      bus,
    input  logic            cmp,
    output logic [N_CH-1:0] diode_sel,
    output logic            pii,
    output logic            pi,
    output logic            pa,
    output logic            pb,
    output logic            pre_chrg,
    output logic            cmp_p1,
    output logic            cmp_p2
);

    localparam int TMR_MAX = (PRE_CYC > PH_CYC) ? ((PRE_CYC > CHG_CYC) ? PRE_CYC : CHG_CYC)
                                                : ((PH_CYC > CHG_CYC) ? PH_CYC : CHG_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRECHARGE, S_BLANK_D, S_DIODE, S_BLANK_B, S_BIGDIODE, S_CHARGE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [OSR_W-1:0]   iter_q, iter_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [CH_W-1:0]    ch_q, ch_d;

    logic ch_ok;
    logic last_iter;
    logic tmr_zero;
    logic decision;

    assign ch_ok     = (32'(bus.ch_sel) < N_CH);
    assign last_iter = (iter_q == '1);
    assign tmr_zero  = (tmr_q == '0);

`ifdef TSEQ_CHOP_EN
    logic chop_q, chop_d;

    // Chop phase flips as each BIGDIODE is entered; BLANK_B always leads into BIGDIODE.
    always_comb begin
        chop_d = chop_q;
        if (state_q == S_BLANK_B) chop_d = ~chop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chop_q <= 1'b0;
        else          chop_q <= chop_d;
    end

    assign decision = cmp ^ chop_q;
    assign cmp_p1   = ~chop_q;
    assign cmp_p2   = chop_q;
`else
    assign decision = cmp;
    assign cmp_p1   = 1'b1;
    assign cmp_p2   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        iter_d  = iter_q;
        acc_d   = acc_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && ch_ok) begin
                    ch_d    = bus.ch_sel;
                    acc_d   = '0;
                    iter_d  = '0;
                    tmr_d   = TMR_W'(PRE_CYC - 1);
                    state_d = S_PRECHARGE;
                end
            end
            S_PRECHARGE: begin
                if (tmr_zero) state_d = S_BLANK_D;
                else          tmr_d   = tmr_q - TMR_W'(1);
            end
            S_BLANK_D: begin
                tmr_d   = TMR_W'(PH_CYC - 1);
                state_d = S_DIODE;
            end
            S_DIODE: begin
                if (tmr_zero) state_d = S_BLANK_B;
                else          tmr_d   = tmr_q - TMR_W'(1);
            end
            S_BLANK_B: begin
                tmr_d   = TMR_W'(PH_CYC - 1);
                state_d = S_BIGDIODE;
            end
            S_BIGDIODE: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (decision) begin
                    acc_d   = acc_q + RES_W'(1);
                    tmr_d   = TMR_W'(CHG_CYC - 1);
                    state_d = S_CHARGE;
                end else if (last_iter) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + OSR_W'(1);
                    state_d = S_BLANK_D;
                end
            end
            S_CHARGE: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (last_iter) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + OSR_W'(1);
                    state_d = S_BLANK_D;
                end
            end
            S_DONE: begin
                if (bus.ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            iter_q  <= '0;
            acc_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            iter_q  <= iter_d;
            acc_q   <= acc_d;
            ch_q    <= ch_d;
        end
    end

    // Switch controls decode only from registered state so reset clears them asynchronously.
    always_comb begin
        pii        = 1'b0;
        pi         = 1'b0;
        pa         = 1'b0;
        pb         = 1'b0;
        pre_chrg   = 1'b0;
        diode_sel  = '0;
        bus.busy   = (state_q != S_IDLE);
        bus.valid  = (state_q == S_DONE);
        bus.result = (state_q == S_DONE) ? acc_q : '0;
        if (state_q != S_IDLE && state_q != S_DONE) diode_sel = N_CH'(1) << ch_q;
        case (state_q)
            S_PRECHARGE: pre_chrg = 1'b1;
            S_DIODE:     pii      = 1'b1;
            S_BIGDIODE:  pi       = 1'b1;
            S_CHARGE: begin
                pa = 1'b1;
                pb = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tseq_ctrl.sv
// Bench for tseq_ctrl: table vectors, randomized conversions against a phase-arithmetic model, reset and range corner cases.
module tb_tseq_ctrl;
    localparam int N_CH = 4;
    localparam int OSR  = 3;
    localparam int PRE  = 4;
    localparam int PH   = 3;
    localparam int CHG  = 2;
    localparam int NIT  = 1 << OSR;
`ifdef TSEQ_CHOP_EN
    localparam int EXP_TOG = NIT;
`else
    localparam int EXP_TOG = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic cmp;
    logic [N_CH-1:0] diode_sel;
    logic pii, pi, pa, pb, pre_chrg, cmp_p1, cmp_p2;

    logic       cmp6;
    logic [5:0] diode_sel6;
    logic pii6, pi6, pa6, pb6, pre6, p1_6, p2_6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tseq_ctrl_if #(.CH_W(2), .RES_W(OSR + 1)) bus ();
    tseq_ctrl_if #(.CH_W(3), .RES_W(OSR + 1)) bus6 ();

    tseq_ctrl #(.N_CH(N_CH), .OSR_W(OSR), .PRE_CYC(PRE), .PH_CYC(PH), .CHG_CYC(CHG)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .cmp(cmp), .diode_sel(diode_sel),
        .pii(pii), .pi(pi), .pa(pa), .pb(pb), .pre_chrg(pre_chrg), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2)
    );

    tseq_ctrl #(.N_CH(6), .OSR_W(OSR), .PRE_CYC(PRE), .PH_CYC(PH), .CHG_CYC(CHG)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .bus(bus6), .cmp(cmp6), .diode_sel(diode_sel6),
        .pii(pii6), .pi(pi6), .pa(pa6), .pb(pb6), .pre_chrg(pre6), .cmp_p1(p1_6), .cmp_p2(p2_6)
    );

    typedef struct {
        int         ch;
        logic [7:0] pat;
        int         rdy_dly;
        bit         poke;
        int         exp_res;
        int         exp_len;
        logic [3:0] exp_sel;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every iteration costs two blanks plus two phases; each one adds a charge packet.
    function automatic int model_ones(input logic [7:0] p);
        int s = 0;
        for (int i = 0; i < NIT; i++) s += int'(p[i]);
        return s;
    endfunction

    function automatic int model_len(input logic [7:0] p);
        return 1 + PRE + NIT * (2 + 2 * PH) + CHG * model_ones(p);
    endfunction

    function automatic logic [31:0] rst_vec();
        return {bus.busy, bus.valid, 4'(bus.result), diode_sel, pii, pi, pa, pb, pre_chrg, cmp_p1, cmp_p2};
    endfunction

    // Caller is aligned 1 time unit after a rising edge.
    task automatic run_conv(input vec_t v);
        int cyc, it, charges, bbm, selbad, tog, chopbad;
        logic prev_pi, prev_pii, prev_pa, prev_pre, prev_p1;
        bus.ch_sel = 2'(v.ch);
        bus.start  = 1'b1;
        bus.ready  = 1'b0;
        cmp        = 1'b0;
        @(posedge clk); #1;
        bus.start = v.poke;
        if (v.poke) bus.ch_sel = 2'(v.ch) ^ 2'b01;
        cyc = 1; it = 0; charges = 0; bbm = 0; selbad = 0; tog = 0; chopbad = 0;
        prev_pi = 0; prev_pii = 0; prev_pa = 0; prev_pre = 0; prev_p1 = cmp_p1;
        chk("precharge_first", {31'd0, pre_chrg}, 32'd1);
        while (!bus.valid && cyc < 400) begin
            if (pi && !prev_pi) begin
                cmp = (it < NIT) ? (v.pat[it] ^ cmp_p2) : 1'b0;
                it++;
                if (prev_pii) bbm++;
            end
            if (pii && !prev_pii && (prev_pi || prev_pa || prev_pre)) bbm++;
            if (pa && !prev_pa) charges++;
            if ($countones({pre_chrg, pii, pi, pa | pb}) > 1 || pa != pb) bbm++;
            if (diode_sel != v.exp_sel || !bus.busy) selbad++;
            if (cmp_p1 == cmp_p2) chopbad++;
            if (cmp_p1 != prev_p1) tog++;
            prev_pi = pi; prev_pii = pii; prev_pa = pa; prev_pre = pre_chrg; prev_p1 = cmp_p1;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("valid_seen", {31'd0, bus.valid}, 32'd1);
        chk("conv_len", cyc, v.exp_len);
        chk("result", 32'(bus.result), v.exp_res);
        chk("charge_phases", charges, v.exp_res);
        chk("bigdiode_phases", it, NIT);
        chk("break_before_make", bbm, 0);
        chk("diode_sel_hold", selbad, 0);
        chk("chop_complement", chopbad, 0);
        chk("cmp_p1_toggles", tog, EXP_TOG);
        chk("done_outputs", {diode_sel, bus.busy, pii, pi, pa, pb, pre_chrg}, {4'd0, 1'b1, 5'd0});
        for (int d = 0; d < v.rdy_dly; d++) begin
            @(posedge clk); #1;
            chk("hold_valid_result", {bus.valid, 4'(bus.result)}, {1'b1, 4'(v.exp_res)});
        end
        bus.ready = 1'b1;
        @(posedge clk); #1;
        bus.ready = 1'b0;
        chk("return_idle", {bus.valid, bus.busy}, 2'b00);
    endtask

    initial begin
        int k, n;
        logic prev;
        vec_t rv;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.ch_sel = '0; bus.ready = 1'b0;
        bus6.start = 1'b0; bus6.ch_sel = '0; bus6.ready = 1'b0;
        cmp = 1'b0; cmp6 = 1'b0;

        tbl[0] = '{ch: 2, pat: 8'h00, rdy_dly: 0, poke: 0, exp_res: 0, exp_len: 69, exp_sel: 4'b0100};
        tbl[1] = '{ch: 0, pat: 8'hFF, rdy_dly: 0, poke: 0, exp_res: 8, exp_len: 85, exp_sel: 4'b0001};
        tbl[2] = '{ch: 1, pat: 8'h55, rdy_dly: 5, poke: 0, exp_res: 4, exp_len: 77, exp_sel: 4'b0010};
        tbl[3] = '{ch: 3, pat: 8'h80, rdy_dly: 2, poke: 1, exp_res: 1, exp_len: 71, exp_sel: 4'b1000};
        tbl[4] = '{ch: 2, pat: 8'h3C, rdy_dly: 1, poke: 1, exp_res: 4, exp_len: 77, exp_sel: 4'b0100};

        #3;
        chk("reset_outputs", rst_vec(), 32'h2);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", rst_vec(), 32'h2);

        foreach (tbl[i]) run_conv(tbl[i]);

        for (int r = 0; r < 6; r++) begin
            rv.ch      = int'($urandom_range(0, N_CH - 1));
            rv.pat     = 8'($urandom);
            rv.rdy_dly = int'($urandom_range(0, 3));
            rv.poke    = 1'($urandom);
            rv.exp_res = model_ones(rv.pat);
            rv.exp_len = model_len(rv.pat);
            rv.exp_sel = 4'(1 << rv.ch);
            run_conv(rv);
        end

        // Out-of-range channel on a 6-channel instance must be ignored; an in-range one accepted.
        bus6.start = 1'b1;
        bus6.ch_sel = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("ch7_ignored", {bus6.busy, 2'(diode_sel6 != 0)}, 3'b000);
        bus6.ch_sel = 3'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("ch6_ignored", {bus6.busy, 2'(diode_sel6 != 0)}, 3'b000);
        bus6.ch_sel = 3'd5;
        @(posedge clk); #1;
        bus6.start = 1'b0;
        chk("ch5_accepted", {bus6.busy, diode_sel6}, {1'b1, 6'b100000});

        // Reset in the middle of the third BIGDIODE phase.
        bus.ch_sel = 2'd1; bus.start = 1'b1; cmp = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0; k = 0; prev = 1'b0;
        while (n < 3 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (pi && !prev) n++;
            prev = pi;
        end
        chk("reached_bigdiode3", {31'd0, pi}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", rst_vec(), 32'h2);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (bus.valid || bus.busy) n++;
        end
        chk("no_valid_after_reset", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tseq_ctrl.md
TSEQ_CTRL -- requirements
Module: tseq_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of diode sensor channels (1..8).
REQ-002 SHALL have parameter OSR_W, default 6, log2 of charge-balance iterations per conversion.
REQ-003 SHALL have parameter PRE_CYC, default 26, precharge length in cycles (>=1).
REQ-004 SHALL have parameter PH_CYC, default 8, DIODE and BIGDIODE phase length in cycles (>=1).
REQ-005 SHALL have parameter CHG_CYC, default 5, charge-packet length in cycles (>=1).
REQ-006 SHALL derive CH_W = max(1, clog2(N_CH)) and RES_W = OSR_W+1.
REQ-007 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-008 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have port start  in  1  conversion request, level-sampled in IDLE.
REQ-010 SHALL have port ch_sel  in  CH_W  channel to convert, sampled with start.
REQ-011 SHALL have port cmp  in  1  comparator decision, synchronous to clk.
REQ-012 SHALL have port ready  in  1  consumer accepts result.
REQ-013 SHALL have port diode_sel  out  N_CH  one-hot enable of selected diode.
REQ-014 SHALL have ports pii, pi, pa, pb, pre_chrg  out  1 each  small-current, big-current, charge-packet A/B, precharge switch controls.
REQ-015 SHALL have ports cmp_p1, cmp_p2  out  1 each  comparator chop phases, always complementary.
REQ-016 SHALL have ports busy  out  1, valid  out  1, result  out  RES_W  (conversion status, result handshake, ones-count).

Function
REQ-017 SHALL implement states IDLE, PRECHARGE, BLANK_D, DIODE, BLANK_B, BIGDIODE, CHARGE, DONE.
REQ-018 In IDLE, start=1 with ch_sel<N_CH SHALL latch ch_sel, clear accumulator and iteration counter, and enter PRECHARGE next cycle; start with ch_sel>=N_CH SHALL be ignored.
REQ-019 PRECHARGE SHALL last exactly PRE_CYC cycles with pre_chrg=1, then enter BLANK_D.
REQ-020 BLANK_D and BLANK_B SHALL last 1 cycle each with pii=pi=pa=pb=0 (break-before-make).
REQ-021 DIODE SHALL last PH_CYC cycles with pii=1, then BLANK_B; BIGDIODE SHALL last PH_CYC cycles with pi=1.
REQ-022 cmp SHALL be sampled on the last BIGDIODE cycle; decision 1 -> CHARGE (pa=pb=1 for CHG_CYC cycles, accumulator +1); decision 0 -> skip CHARGE.
REQ-023 After each iteration, if iteration counter = 2^OSR_W-1, next state SHALL be DONE, else counter +1 and BLANK_D.
REQ-024 diode_sel SHALL be one-hot of latched channel in all states except IDLE and DONE, else all zero.
REQ-025 In DONE, valid=1 and result=accumulator SHALL be held stable until ready=1; the valid&&ready cycle returns to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-027 Accumulator SHALL be RES_W bits; all-ones input yields 2^OSR_W with no overflow.
REQ-028 Conversion length (start-sample cycle to first valid cycle) SHALL be 1 + PRE_CYC + 2^OSR_W*(2+2*PH_CYC) + CHG_CYC*(ones count) cycles.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, all outputs 0 except cmp_p1=1, accumulator and counters 0, regardless of state.
REQ-030 Reset mid-conversion SHALL discard the partial result; no valid pulse follows release.

Configuration
REQ-031 Macro TSEQ_CHOP_EN defined: cmp_p1/cmp_p2 SHALL toggle on entry to each BIGDIODE, and decision SHALL equal cmp XOR cmp_p2.
REQ-032 Macro TSEQ_CHOP_EN undefined: cmp_p1=1, cmp_p2=0 constant, decision = cmp.

Verification (PRE_CYC=4, PH_CYC=3, CHG_CYC=2, OSR_W=3, N_CH=4, no chop unless stated)
REQ-033 start=1, ch_sel=2, cmp=0 -> diode_sel=4'b0100, valid after 69 cycles, result=0.
REQ-034 start=1, cmp=1 constant -> 8 CHARGE phases, valid after 85 cycles, result=8.
REQ-035 cmp alternating 1/0 per iteration -> result=4, valid after 77 cycles; ready=0 for 5 cycles -> valid and result held.
REQ-036 ch_sel=5 with start=1 -> remains IDLE, busy=0; start during conversion -> no effect.
REQ-037 reset_n=0 during BIGDIODE of iteration 3 -> all outputs at reset values asynchronously; no valid after release.
REQ-038 TSEQ_CHOP_EN defined, cmp=cmp_p2 every sample -> decision 0 every iteration, result=0; cmp_p1 toggles 8 times.
